// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle control FSM for the LEGv8 core: opcode decode, immediate-format select,
// FETCH/DECODE/EXEC/MEM/WB sequencing with memory handshakes, retire counter and undefined-opcode trap.
module legv8_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic [10:0]      Opcode,
    input  logic             Zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             PCSrc,
    output logic [2:0]       SignOp,
    output logic             ALUSrc,
    output logic [3:0]       ALUOp,
    output logic             Reg2Loc,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [3:0] {
        C_ADD, C_SUB, C_AND, C_ORR, C_ADDI, C_SUBI,
        C_LDUR, C_STUR, C_B, C_CBZ, C_MOVZ, C_UNDEF
    } cls_t;

    state_t state, state_nx;
    cls_t   cls_dec, cls_q, cls_cur;

    function automatic cls_t decode_op(input logic [10:0] op);
        if (op == 11'h7C2)                     return C_LDUR;
        if (op == 11'h7C0)                     return C_STUR;
        if (op == 11'h458)                     return C_ADD;
        if (op == 11'h658)                     return C_SUB;
        if (op == 11'h450)                     return C_AND;
        if (op == 11'h550)                     return C_ORR;
        if (op >= 11'h488 && op <= 11'h489)    return C_ADDI;
        if (op >= 11'h688 && op <= 11'h689)    return C_SUBI;
        if (op >= 11'h0A0 && op <= 11'h0BF)    return C_B;
        if (op >= 11'h5A0 && op <= 11'h5A7)    return C_CBZ;
        if (op >= 11'h694 && op <= 11'h697)    return C_MOVZ;
        return C_UNDEF;
    endfunction

    function automatic logic [2:0] sign_of(input cls_t c);
        case (c)
            C_LDUR, C_STUR: return 3'b001;
            C_B:            return 3'b010;
            C_CBZ:          return 3'b011;
            C_MOVZ:         return 3'b100;
            default:        return 3'b000;
        endcase
    endfunction

    // The IR is stable in DECODE, so decode is taken live there and latched for later states.
    always_comb begin
        cls_dec = decode_op(Opcode);
        cls_cur = (state == S_DECODE) ? cls_dec : cls_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state <= S_FETCH;
        else         state <= state_nx;
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            cls_q       <= C_ADD;
            instr_count <= '0;
        end else begin
            if (state == S_DECODE) cls_q <= cls_dec;
            if (PCWrite)           instr_count <= instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FETCH:  if (imem_ready) state_nx = S_DECODE;
            S_DECODE: begin
                if (cls_cur == C_UNDEF)  state_nx = S_TRAP;
                else if (cls_cur == C_B) state_nx = S_FETCH;
                else                     state_nx = S_EXEC;
            end
            S_EXEC: begin
                if (cls_cur == C_CBZ)                             state_nx = S_FETCH;
                else if (cls_cur inside {C_LDUR, C_STUR})         state_nx = S_MEM;
                else                                              state_nx = S_WB;
            end
            S_MEM:    if (dmem_ready) state_nx = (cls_cur == C_STUR) ? S_FETCH : S_WB;
            S_WB:     state_nx = S_FETCH;
            S_TRAP:   state_nx = S_TRAP;
            default:  state_nx = S_FETCH;
        endcase
    end

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        IRWrite  = 1'b0;
        PCWrite  = 1'b0;
        PCSrc    = 1'b0;
        SignOp   = sign_of(cls_cur);
        ALUSrc   = 1'b0;
        ALUOp    = 4'b0010;
        Reg2Loc  = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        RegWrite = 1'b0;
        illegal  = 1'b0;
        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB})
            Reg2Loc = cls_cur inside {C_STUR, C_CBZ};
        case (state)
            // Gated by reset so no strobe leaks out while the core is held in reset.
            S_FETCH:  IRWrite = imem_ready & resetl;
            S_DECODE: begin
                if (cls_cur == C_B) begin
                    PCWrite = 1'b1;
                    PCSrc   = 1'b1;
                end
            end
            S_EXEC: begin
                case (cls_cur)
                    C_SUB:          ALUOp = 4'b0110;
                    C_AND:          ALUOp = 4'b0000;
                    C_ORR:          ALUOp = 4'b0001;
                    C_ADDI, C_LDUR,
                    C_STUR:         ALUSrc = 1'b1;
                    C_SUBI: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 4'b0110;
                    end
                    C_CBZ: begin
                        ALUOp   = 4'b0111;
                        PCWrite = 1'b1;
                        PCSrc   = Zero;
                    end
                    C_MOVZ: begin
                        ALUSrc = 1'b1;
                        ALUOp  = 4'b0111;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                MemRead  = (cls_cur == C_LDUR);
                MemWrite = (cls_cur == C_STUR);
                PCWrite  = (cls_cur == C_STUR) & dmem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemToReg = (cls_cur == C_LDUR);
                PCWrite  = 1'b1;
            end
            S_TRAP:   illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Self-checking bench: an instruction-level model expands each instruction into its expected
// per-cycle output vectors, and a compare process checks the DUT against them every cycle.
module tb_legv8_multicycle_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          resetl = 1'b0;
    logic [10:0]   opcode = 11'h0;
    logic          zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic          irwrite, pcwrite, pcsrc, alusrc, reg2loc;
    logic          memread, memwrite, memtoreg, regwrite, illegal;
    logic [2:0]    signop;
    logic [3:0]    aluop;
    logic [CW-1:0] instr_count;

    legv8_multicycle_ctrl #(.CNT_W(CW)) dut (
        .CLK(clk), .resetl(resetl), .Opcode(opcode), .Zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .IRWrite(irwrite), .PCWrite(pcwrite), .PCSrc(pcsrc), .SignOp(signop),
        .ALUSrc(alusrc), .ALUOp(aluop), .Reg2Loc(reg2loc), .MemRead(memread),
        .MemWrite(memwrite), .MemToReg(memtoreg), .RegWrite(regwrite),
        .illegal(illegal), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef enum {K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_SUBI, K_LDUR, K_STUR,
                  K_B, K_CBZ, K_MOVZ, K_UNDEF} kind_t;

    typedef struct packed {
        logic       irw, pcw, pcs;
        logic [2:0] sop;
        logic       alus;
        logic [3:0] aluop;
        logic       r2l, mr, mw, m2r, rw, ill;
    } ov_t;

    typedef struct {
        logic [10:0] op;
        logic        imem, dmem, zr;
        ov_t         exp, msk;
    } step_t;

    step_t         q[$];
    ov_t           act, cur_exp, cur_msk, rst_exp;
    logic [CW-1:0] m_cnt = '0, cur_cnt = '0;
    logic          chk_en = 1'b0;
    int            total = 0, bad = 0, mr_cyc = 0, rw_cyc = 0, cyc = 0;

    assign act = {irwrite, pcwrite, pcsrc, signop, alusrc, aluop,
                  reg2loc, memread, memwrite, memtoreg, regwrite, illegal};

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check($sformatf("cycle%0d outputs", cyc), 32'(act & cur_msk), 32'(cur_exp & cur_msk));
            check($sformatf("cycle%0d instr_count", cyc), 32'(instr_count), 32'(cur_cnt));
            if (memread)  mr_cyc++;
            if (regwrite) rw_cyc++;
            cyc++;
        end
    end

    // ---------------- instruction-level model ----------------
    function automatic kind_t classify(input logic [10:0] op);
        int lo[11] = '{'h458, 'h658, 'h450, 'h550, 'h488, 'h688, 'h7C2, 'h7C0, 'h0A0, 'h5A0, 'h694};
        int hi[11] = '{'h458, 'h658, 'h450, 'h550, 'h489, 'h689, 'h7C2, 'h7C0, 'h0BF, 'h5A7, 'h697};
        for (int i = 0; i < 11; i++)
            if (int'(op) >= lo[i] && int'(op) <= hi[i]) return kind_t'(i);
        return K_UNDEF;
    endfunction

    function automatic logic [2:0] sop_of(input kind_t k);
        case (k)
            K_LDUR, K_STUR: return 3'd1;
            K_B:            return 3'd2;
            K_CBZ:          return 3'd3;
            K_MOVZ:         return 3'd4;
            default:        return 3'd0;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input kind_t k);  // {ALUSrc, ALUOp}
        case (k)
            K_SUB:                  return 5'b0_0110;
            K_AND:                  return 5'b0_0000;
            K_ORR:                  return 5'b0_0001;
            K_ADDI, K_LDUR, K_STUR: return 5'b1_0010;
            K_SUBI:                 return 5'b1_0110;
            K_CBZ:                  return 5'b0_0111;
            K_MOVZ:                 return 5'b1_0111;
            default:                return 5'b0_0010;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic add_step(input logic [10:0] op, input logic im, input logic dm,
                            input logic zr, input ov_t e, input ov_t m);
        step_t s;
        s.op = op; s.imem = im; s.dmem = dm; s.zr = zr; s.exp = e; s.msk = m;
        q.push_back(s);
    endtask

    // Expand one instruction into expected cycles; ignored inputs get random noise.
    task automatic build(input logic [10:0] op, input logic zr, input int iw, input int dw);
        kind_t      k   = classify(op);
        logic [2:0] sop = sop_of(k);
        logic       r2  = (k == K_STUR || k == K_CBZ);
        ov_t        e, m, base;
        base = '1; base.sop = '0; base.alus = 1'b0; base.aluop = '0; base.r2l = 1'b0;
        for (int i = 0; i < iw; i++) add_step(op, 1'b0, rb(), rb(), '0, base);
        e = '0; e.irw = 1'b1;
        add_step(op, 1'b1, rb(), rb(), e, base);
        e = '0; m = base;
        if (k != K_UNDEF) begin
            m.sop = '1; m.r2l = 1'b1; e.sop = sop; e.r2l = r2;
        end
        if (k == K_B) begin e.pcw = 1'b1; e.pcs = 1'b1; end
        add_step(op, rb(), rb(), rb(), e, m);
        if (k == K_UNDEF) begin
            e = '0; e.ill = 1'b1;
            repeat (20) add_step(op, rb(), rb(), rb(), e, base);
            return;
        end
        if (k == K_B) return;
        m.alus = 1'b1; m.aluop = '1;
        e = '0; e.sop = sop; e.r2l = r2; {e.alus, e.aluop} = alu_of(k);
        if (k == K_CBZ) begin
            e.pcw = 1'b1; e.pcs = zr;
            add_step(op, rb(), rb(), zr, e, m);
            return;
        end
        add_step(op, rb(), rb(), rb(), e, m);
        m.alus = 1'b0; m.aluop = '0;
        e = '0; e.sop = sop; e.r2l = r2;
        if (k == K_LDUR || k == K_STUR) begin
            e.mr = (k == K_LDUR); e.mw = (k == K_STUR);
            for (int i = 0; i < dw; i++) add_step(op, rb(), 1'b0, rb(), e, m);
            e.pcw = (k == K_STUR);
            add_step(op, rb(), 1'b1, rb(), e, m);
            if (k == K_STUR) return;
            e = '0; e.sop = sop; e.r2l = r2;
        end
        e.rw = 1'b1; e.m2r = (k == K_LDUR); e.pcw = 1'b1;
        add_step(op, rb(), rb(), rb(), e, m);
    endtask

    task automatic run_n(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            @(posedge clk); #1;
            opcode = s.op; imem_ready = s.imem; dmem_ready = s.dmem; zero = s.zr;
            cur_exp = s.exp; cur_msk = s.msk; cur_cnt = m_cnt; chk_en = 1'b1;
            if (s.exp.pcw) m_cnt = m_cnt + 1'b1;
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    // One untracked FETCH cycle with imem_ready low, so literal checks see settled state.
    task automatic idle();
        @(posedge clk); #1;
        chk_en = 1'b0; imem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en = 1'b0; resetl = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
        #2;
        check("reset outputs", 32'(act), 32'(rst_exp));
        check("reset instr_count", 32'(instr_count), 32'd0);
        @(negedge clk) imem_ready = 1'b0;
        @(posedge clk); #1;
        resetl = 1'b1; m_cnt = '0;
    endtask

    function automatic logic [10:0] gen_op(input kind_t k);
        logic [10:0] op;
        case (k)
            K_ADD:  return 11'h458;
            K_SUB:  return 11'h658;
            K_AND:  return 11'h450;
            K_ORR:  return 11'h550;
            K_ADDI: return 11'h488 + 11'($urandom_range(0, 1));
            K_SUBI: return 11'h688 + 11'($urandom_range(0, 1));
            K_LDUR: return 11'h7C2;
            K_STUR: return 11'h7C0;
            K_B:    return 11'h0A0 + 11'($urandom_range(0, 31));
            K_CBZ:  return 11'h5A0 + 11'($urandom_range(0, 7));
            K_MOVZ: return 11'h694 + 11'($urandom_range(0, 3));
            default: begin
                do op = 11'($urandom); while (classify(op) != K_UNDEF);
                return op;
            end
        endcase
    endfunction

    initial begin
        int rw0;
        int c0;
        kind_t k;
        rst_exp = '0; rst_exp.aluop = 4'b0010;

        do_reset();

        // ADD with no waits: IRWrite at c0, RegWrite+PCWrite at c3, one retire.
        build(11'h458, 1'b0, 0, 0); run_all(); idle();
        check("add instr_count", 32'(instr_count), 32'd1);
        check("add regwrite cycles", 32'(rw_cyc), 32'd1);

        // LDUR with dmem_ready low three cycles: MemRead held four cycles, 8 cycles total.
        mr_cyc = 0; c0 = cyc;
        build(11'h7C2, 1'b0, 0, 3); run_all(); idle();
        check("ldur memread cycles", 32'(mr_cyc), 32'd4);
        check("ldur cycle count", 32'(cyc - c0), 32'd8);
        check("ldur instr_count", 32'(instr_count), 32'd2);

        // CBZ taken and not taken: no register write.
        rw0 = rw_cyc;
        build(11'h5A3, 1'b1, 0, 0); build(11'h5A3, 1'b0, 1, 0); run_all(); idle();
        check("cbz regwrite cycles", 32'(rw_cyc - rw0), 32'd0);
        check("cbz instr_count", 32'(instr_count), 32'd4);

        // B then MOVZ.
        build(11'h0A5, 1'b0, 0, 0); build(11'h695, 1'b0, 2, 0); run_all(); idle();
        check("b movz instr_count", 32'(instr_count), 32'd6);

        // Undefined opcode traps and holds.
        build(11'h7FF, 1'b0, 0, 0); run_all(); idle();
        check("trap illegal", 32'(illegal), 32'd1);
        check("trap instr_count", 32'(instr_count), 32'd6);
        do_reset();

        // Reset asserted in the middle of a load's memory wait.
        build(11'h7C2, 1'b0, 0, 10); run_n(5);
        @(posedge clk); #1;
        chk_en = 1'b0; dmem_ready = 1'b0;
        check("pre-reset memread", 32'(memread), 32'd1);
        #2 resetl = 1'b0;
        #1;
        check("mid-mem reset memread", 32'(memread), 32'd0);
        check("mid-mem reset outputs", 32'(act), 32'(rst_exp));
        q.delete();
        @(posedge clk); #1;
        imem_ready = 1'b0; resetl = 1'b1; m_cnt = '0;

        // Counter wrap with a 4-bit counter: 16 retires.
        do_reset();
        repeat (15) build(gen_op(K_B), 1'b0, 0, 0);
        run_all(); idle();
        check("count before wrap", 32'(instr_count), 32'd15);
        build(gen_op(K_ADD), 1'b0, 0, 0); run_all(); idle();
        check("count wrapped", 32'(instr_count), 32'd0);

        // Randomized instruction stream with random handshake waits.
        do_reset();
        repeat (400) begin
            k = ($urandom_range(0, 99) < 4) ? K_UNDEF : kind_t'($urandom_range(0, 10));
            build(gen_op(k), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
            run_all();
            if (k == K_UNDEF) do_reset();
        end
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
